// File: rtl/data_path.sv
// GCD datapath: operand registers A and B with input muxes, a wrapping
// subtractor and the status comparators used by an external controller.
module data_path #(
    parameter int numOfBits = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [numOfBits-1:0] In_A,
    input  logic [numOfBits-1:0] In_B,
    input  logic [1:0]           Asel,
    input  logic                 Aen,
    input  logic                 Bsel,
    input  logic                 Ben,
    output logic [numOfBits-1:0] Result,
    output logic                 B_eq_0,
    output logic                 A_lessThan_B
);

    logic [numOfBits-1:0] a_q, a_d;
    logic [numOfBits-1:0] b_q, b_d;
    logic [numOfBits-1:0] diff;

    // Borrow is dropped: A < B wraps modulo 2^N.
    assign diff = a_q - b_q;

    always_comb begin
        a_d = a_q;
        if (Aen) begin
            unique case (Asel)
                2'd0:    a_d = In_A;
                2'd1:    a_d = diff;
                2'd2:    a_d = b_q;
                default: a_d = a_q;
            endcase
        end
    end

    always_comb begin
        b_d = b_q;
        if (Ben) begin
            b_d = Bsel ? In_B : a_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign Result       = a_q;
    assign B_eq_0       = (b_q == '0);
    assign A_lessThan_B = (a_q < b_q);

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: a reference model of A/B pushes expected
// outputs per driven cycle; they are popped and compared after the edge.
module tb_data_path;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] In_A, In_B;
    logic [1:0]   Asel;
    logic         Aen, Bsel, Ben;
    logic [N-1:0] Result;
    logic         B_eq_0, A_lessThan_B;

    typedef struct packed {
        logic [N-1:0] res;
        logic         beq0;
        logic         altb;
    } exp_t;

    exp_t         sb_q[$];
    logic [N-1:0] ma, mb;
    int           checks   = 0;
    int           failures = 0;

    data_path #(.numOfBits(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .In_A         (In_A),
        .In_B         (In_B),
        .Asel         (Asel),
        .Aen          (Aen),
        .Bsel         (Bsel),
        .Ben          (Ben),
        .Result       (Result),
        .B_eq_0       (B_eq_0),
        .A_lessThan_B (A_lessThan_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.res  = ma;
        e.beq0 = (mb == 0);
        e.altb = (ma < mb);
        sb_q.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_result"}, 32'(Result), 32'(e.res));
            check({tag, "_beq0"},   32'(B_eq_0), 32'(e.beq0));
            check({tag, "_altb"},   32'(A_lessThan_B), 32'(e.altb));
        end
    endtask

    task automatic step(input string tag, input logic [N-1:0] ia, input logic [N-1:0] ib,
                        input logic [1:0] as, input logic ae, input logic bs, input logic be);
        logic [N-1:0] na, nb, sub;
        In_A = ia; In_B = ib; Asel = as; Aen = ae; Bsel = bs; Ben = be;
        sub = ma - mb;
        na  = ma;
        if (ae) begin
            case (as)
                2'd0: na = ia;
                2'd1: na = sub;
                2'd2: na = mb;
                default: na = ma;
            endcase
        end
        nb = be ? (bs ? ib : ma) : mb;
        ma = na;
        mb = nb;
        push_model();
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        int iter;
        ma = '0; mb = '0;
        rst_n = 1'b0;
        Aen = 1'b1; Ben = 1'b1; Asel = 2'd0; Bsel = 1'b1;
        In_A = N'($urandom); In_B = N'($urandom);
        #1;
        push_model();
        compare_out("reset_t0");
        // Enables high with changing data must not disturb reset.
        for (int i = 0; i < 3; i++) begin
            In_A = N'($urandom_range(1, 31)); In_B = N'($urandom_range(1, 31));
            Asel = 2'(i);
            push_model();
            @(posedge clk);
            #1;
            compare_out("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        step("load", 5'd6, 5'd3, 2'd0, 1'b1, 1'b1, 1'b1);
        step("sub1", 5'd0, 5'd0, 2'd1, 1'b1, 1'b0, 1'b0);
        step("sub2", 5'd0, 5'd0, 2'd1, 1'b1, 1'b0, 1'b0);
        step("swap", 5'd0, 5'd0, 2'd2, 1'b1, 1'b0, 1'b1);
        check("gcd63_const", 32'(Result), 32'd3);

        for (int i = 0; i < 5; i++)
            step("hold", N'($urandom), N'($urandom), 2'($urandom), 1'b0, 1'($urandom), 1'b0);

        step("load_wrap", 5'd2, 5'd5, 2'd0, 1'b1, 1'b1, 1'b1);
        step("wrap", 5'd0, 5'd0, 2'd1, 1'b1, 1'b0, 1'b0);
        check("wrap_const", 32'(Result), 32'd29);

        step("hold_a", 5'd7, 5'd9, 2'd3, 1'b1, 1'b1, 1'b0);
        step("load_b_only", 5'd1, 5'd31, 2'd3, 1'b0, 1'b1, 1'b1);
        step("b_from_a", 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);

        // Full GCD(21,12) driven by a controller loop over the model flags.
        step("gcd_load", 5'd21, 5'd12, 2'd0, 1'b1, 1'b1, 1'b1);
        iter = 0;
        while (mb != 0 && iter < 64) begin
            if (ma < mb) step("gcd_swap", 5'd0, 5'd0, 2'd2, 1'b1, 1'b0, 1'b1);
            else         step("gcd_sub",  5'd0, 5'd0, 2'd1, 1'b1, 1'b0, 1'b0);
            iter++;
        end
        check("gcd_bounded", 32'(iter < 64), 32'd1);
        check("gcd2112_result", 32'(Result), 32'd3);
        check("gcd2112_beq0", 32'(B_eq_0), 32'd1);

        for (int i = 0; i < 20; i++)
            step("random", N'($urandom), N'($urandom), 2'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));

        // Asynchronous reset mid-computation, checked before any clock edge.
        step("pre_async", 5'd13, 5'd17, 2'd0, 1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        ma = '0; mb = '0;
        #1;
        push_model();
        compare_out("async_reset");
        check("async_result_const", 32'(Result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("reload", 5'd10, 5'd4, 2'd0, 1'b1, 1'b1, 1'b1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
